ghost_sprite_renderer: RTL and testbench

GHOST_SPRITE_RENDERER -- requirements
Module: ghost_sprite_renderer

---
 rtl/ghost_pkg.sv | 117 +++++++++++
 rtl/ghost_sprite_rom.sv | 34 +++
 rtl/ghost_sprite_renderer.sv | 162 ++++++++++++++++
 tb/tb_ghost_sprite_renderer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ghost_pkg.sv
// Shared types and constants for the ghost sprite renderer.
// Holds pixel codes, palette, directions, sprite indices and the sprite/shade helpers.
package ghost_pkg;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_e;

    localparam logic [2:0] CODE_BLANK = 3'd0;
    localparam logic [2:0] CODE_BODY  = 3'd1;
    localparam logic [2:0] CODE_EYE   = 3'd2;
    localparam logic [2:0] CODE_W0    = 3'd3;
    localparam logic [2:0] CODE_B0    = 3'd4;
    localparam logic [2:0] CODE_W1    = 3'd5;
    localparam logic [2:0] CODE_B1    = 3'd6;

    localparam logic [7:0] WHITE     = 8'hFF;
    localparam logic [7:0] RED       = 8'hE0;
    localparam logic [7:0] FRT_BLUE  = 8'h03;
    localparam logic [7:0] FRT_PEACH = 8'hF6;
    localparam logic [7:0] BLUE      = 8'h03;

    localparam int SPR_SIDE = 0;
    localparam int SPR_UPDN = 1;
    localparam int SPR_FRT  = 2;

    // Sprite artwork drawn procedurally; d is the sprite edge.
    // The two frill rows alternate code 2/3 in pairs of columns.
    function automatic logic [2:0] spr_code(input int d, input int s,
                                            input int r, input int c);
        logic [2:0] v;
        int         m;
        logic       eyec;
        logic       pup;
        v = CODE_BLANK;
        if (r == 0)      m = 5;
        else if (r == 1) m = 3;
        else if (r == 2) m = 2;
        else             m = 1;
        if (r == d - 3 || r == d - 2) begin
            if (c >= 1 && c <= d - 2)
                v = ((c / 2) % 2 == 0) ? CODE_EYE : CODE_W0;
        end else if (r < d - 3 && c >= m && c <= d - 1 - m) begin
            v = CODE_BODY;
            if (s == SPR_SIDE) begin
                if (r >= 4 && r <= 7 &&
                    ((c >= 5 && c <= 7) || (c >= 11 && c <= 13)))
                    v = (r >= 5 && r <= 6 && (c == 7 || c == 13))
                        ? CODE_B0 : CODE_W0;
                if (r >= 4 && r <= 7 &&
                    ((c >= 2 && c <= 4) || (c >= 8 && c <= 10)))
                    v = (r >= 5 && r <= 6 && (c == 2 || c == 8))
                        ? CODE_B1 : CODE_W1;
            end else if (s == SPR_UPDN) begin
                eyec = (c >= 4 && c <= 7) || (c >= 9 && c <= 12);
                pup  = (c == 5 || c == 6 || c == 10 || c == 11);
                if (eyec && r >= 3 && r <= 5)
                    v = (r == 3 && pup) ? CODE_B0 : CODE_W0;
                if (eyec && r >= 6 && r <= 8)
                    v = (r == 8 && pup) ? CODE_B1 : CODE_W1;
            end else begin
                if (r >= 5 && r <= 6 &&
                    ((c >= 5 && c <= 6) || (c >= 9 && c <= 10)))
                    v = CODE_EYE;
                if (r == 9 && c >= 3 && c <= 12 && (c % 2) == 1)
                    v = CODE_EYE;
            end
        end
        return v;
    endfunction

    // Returns {opaque, color} for one ghost's code.
    function automatic logic [8:0] shade(input logic [2:0] code,
                                         input logic       frow,
                                         input logic [1:0] d,
                                         input logic [7:0] body,
                                         input logic       fr,
                                         input logic       fw,
                                         input logic       ff);
        logic [7:0] eb;
        logic [8:0] r;
        logic       look_a;
        eb     = fr ? (fw ? WHITE : FRT_BLUE) : body;
        look_a = (d == DIR_RIGHT) || (d == DIR_UP);
        r      = '0;
        if (frow) begin
            case (code)
                CODE_BODY: r = {1'b1, eb};
                CODE_EYE:  if (!ff) r = {1'b1, eb};
                CODE_W0:   if (ff)  r = {1'b1, eb};
                default:   r = '0;
            endcase
        end else if (fr) begin
            case (code)
                CODE_BODY, CODE_W0, CODE_B0,
                CODE_W1, CODE_B1: r = {1'b1, eb};
                CODE_EYE: r = {1'b1, fw ? RED : FRT_PEACH};
                default:  r = '0;
            endcase
        end else begin
            case (code)
                CODE_BODY: r = {1'b1, body};
                CODE_EYE:  r = {1'b1, BLUE};
                CODE_W0:   r = {1'b1, look_a ? WHITE : body};
                CODE_B0:   r = {1'b1, look_a ? BLUE : body};
                CODE_W1:   r = {1'b1, look_a ? body : WHITE};
                CODE_B1:   r = {1'b1, look_a ? body : BLUE};
                default:   r = '0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/ghost_sprite_rom.sv
// Three-sprite code table with one registered read port per ghost.
// Ports: clk, rst_n, addr (N_GHOSTS x AW), data (N_GHOSTS x 3-bit code).
module ghost_sprite_rom
    import ghost_pkg::*;
#(
    parameter int N_GHOSTS = 4,
    parameter int SPR_DIM  = 16,
    parameter int AW       = $clog2(3 * SPR_DIM * SPR_DIM)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_GHOSTS*AW-1:0] addr,
    output logic [N_GHOSTS*3-1:0]  data
);

    localparam int DEPTH = 3 * SPR_DIM * SPR_DIM;

    logic [2:0] tab [DEPTH];

    for (genvar a = 0; a < DEPTH; a++) begin : g_tab
        assign tab[a] = spr_code(SPR_DIM, a / (SPR_DIM * SPR_DIM),
                                 (a / SPR_DIM) % SPR_DIM, a % SPR_DIM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else begin
            for (int g = 0; g < N_GHOSTS; g++)
                data[g*3 +: 3] <= tab[addr[g*AW +: AW]];
        end
    end

endmodule

// File: rtl/ghost_sprite_renderer.sv
// Two-stage ghost pixel renderer with fright/flash timing and frill animation.
// Ports: clk, rst_n, frame_tick, fright_start, valid_in, per-ghost row/col/dir/hit/body; valid_out, pixel_out, opaque_out, frightened.
module ghost_sprite_renderer
    import ghost_pkg::*;
#(
    parameter int N_GHOSTS     = 4,
    parameter int SPR_DIM      = 16,
    parameter int FRIGHT_TICKS = 360,
    parameter int FLASH_TICKS  = 120,
    parameter int FLASH_DIV    = 8,
    parameter int FRILL_DIV    = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               frame_tick,
    input  logic                               fright_start,
    input  logic                               valid_in,
    input  logic [N_GHOSTS*$clog2(SPR_DIM)-1:0] row_in,
    input  logic [N_GHOSTS*$clog2(SPR_DIM)-1:0] col_in,
    input  logic [N_GHOSTS*2-1:0]              dir_in,
    input  logic [N_GHOSTS-1:0]                hit_in,
    input  logic [N_GHOSTS*8-1:0]              body_color,
    output logic                               valid_out,
    output logic [7:0]                         pixel_out,
    output logic                               opaque_out,
    output logic                               frightened
);

    localparam int RW  = $clog2(SPR_DIM);
    localparam int AW  = $clog2(3 * SPR_DIM * SPR_DIM);
    localparam int CW  = $clog2(FRIGHT_TICKS + 1);
    localparam int FDW = $clog2(FRILL_DIV + 1);

    logic [CW-1:0]  cnt;
    logic [FDW-1:0] fdiv;
    logic           ff;
    logic           fw;

    logic [N_GHOSTS*AW-1:0] addr;
    logic [N_GHOSTS*3-1:0]  rom_data;
    logic [N_GHOSTS-1:0]    frow;
    logic [1:0]             sel;

    logic                   v1;
    logic [N_GHOSTS-1:0]    hit1;
    logic [N_GHOSTS*2-1:0]  dir1;
    logic [N_GHOSTS*8-1:0]  body1;
    logic [N_GHOSTS-1:0]    frow1;
    logic                   fr1;
    logic                   fw1;
    logic                   ff1;

    logic [8:0] sh;
    logic [8:0] win;

    assign frightened = (cnt != '0);

    // Flash phase is bit 0 of the counter divided by FLASH_DIV.
    assign fw = frightened && (cnt <= CW'(FLASH_TICKS)) &&
                (((cnt / CW'(FLASH_DIV)) & CW'(1)) != '0);

    // A start pulse always wins over a coincident decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            fdiv <= '0;
            ff   <= 1'b0;
        end else begin
            if (fright_start)
                cnt <= CW'(FRIGHT_TICKS);
            else if (frame_tick && cnt != '0)
                cnt <= cnt - 1'b1;
            if (frame_tick) begin
                if (fdiv == FDW'(FRILL_DIV - 1)) begin
                    fdiv <= '0;
                    ff   <= ~ff;
                end else begin
                    fdiv <= fdiv + 1'b1;
                end
            end
        end
    end

    always_comb begin
        addr = '0;
        frow = '0;
        sel  = 2'(SPR_SIDE);
        for (int g = 0; g < N_GHOSTS; g++) begin
            if (frightened)
                sel = 2'(SPR_FRT);
            else if (dir_in[g*2+1])
                sel = 2'(SPR_UPDN);
            else
                sel = 2'(SPR_SIDE);
            addr[g*AW +: AW] = AW'(sel) * AW'(SPR_DIM * SPR_DIM)
                             + AW'(row_in[g*RW +: RW]) * AW'(SPR_DIM)
                             + AW'(col_in[g*RW +: RW]);
            frow[g] = (row_in[g*RW +: RW] == RW'(SPR_DIM - 3)) ||
                      (row_in[g*RW +: RW] == RW'(SPR_DIM - 2));
        end
    end

    ghost_sprite_rom #(
        .N_GHOSTS (N_GHOSTS),
        .SPR_DIM  (SPR_DIM),
        .AW       (AW)
    ) u_rom (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr),
        .data  (rom_data)
    );

    // Mode state is captured alongside the ROM read so a pixel is self-consistent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            hit1  <= '0;
            dir1  <= '0;
            body1 <= '0;
            frow1 <= '0;
            fr1   <= 1'b0;
            fw1   <= 1'b0;
            ff1   <= 1'b0;
        end else begin
            v1    <= valid_in;
            hit1  <= hit_in;
            dir1  <= dir_in;
            body1 <= body_color;
            frow1 <= frow;
            fr1   <= frightened;
            fw1   <= fw;
            ff1   <= ff;
        end
    end

    // Scan high to low so the lowest-index opaque ghost ends up winning.
    always_comb begin
        win = '0;
        sh  = '0;
        for (int g = N_GHOSTS - 1; g >= 0; g--) begin
            sh = hit1[g] ? shade(rom_data[g*3 +: 3], frow1[g],
                                 dir1[g*2 +: 2], body1[g*8 +: 8],
                                 fr1, fw1, ff1) : 9'd0;
            if (sh[8])
                win = sh;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out  <= 1'b0;
            pixel_out  <= '0;
            opaque_out <= 1'b0;
        end else begin
            valid_out  <= v1;
            pixel_out  <= v1 ? win[7:0] : 8'd0;
            opaque_out <= v1 & win[8];
        end
    end

endmodule

// File: tb/tb_ghost_sprite_renderer.sv
// Scoreboard bench for ghost_sprite_renderer.
// Drives pixels on the falling edge; checks due outputs one tick after each rising edge.
module tb_ghost_sprite_renderer;

    localparam int N   = 4;
    localparam int FT  = 360;
    localparam int FLT = 120;
    localparam int FD  = 8;
    localparam int FRD = 8;

    logic          clk;
    logic          rst_n;
    logic          frame_tick;
    logic          fright_start;
    logic          valid_in;
    logic [N*4-1:0] row_in;
    logic [N*4-1:0] col_in;
    logic [N*2-1:0] dir_in;
    logic [N-1:0]   hit_in;
    logic [N*8-1:0] body_color;
    logic          valid_out;
    logic [7:0]    pixel_out;
    logic          opaque_out;
    logic          frightened;

    ghost_sprite_renderer #(
        .N_GHOSTS     (N),
        .SPR_DIM      (16),
        .FRIGHT_TICKS (FT),
        .FLASH_TICKS  (FLT),
        .FLASH_DIV    (FD),
        .FRILL_DIV    (FRD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .fright_start (fright_start),
        .valid_in     (valid_in),
        .row_in       (row_in),
        .col_in       (col_in),
        .dir_in       (dir_in),
        .hit_in       (hit_in),
        .body_color   (body_color),
        .valid_out    (valid_out),
        .pixel_out    (pixel_out),
        .opaque_out   (opaque_out),
        .frightened   (frightened)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [8:0] v;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   cnt   = 0;
    int   fdv   = 0;
    logic ff    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] model(input int k, input int r,
                                         input int d, input logic [7:0] b);
        logic       frow;
        logic       fr;
        logic       fw;
        logic       la;
        logic [7:0] eb;
        frow = (r == 13) || (r == 14);
        fr   = (cnt != 0);
        fw   = fr && (cnt <= FLT) && (((cnt / FD) % 2) == 1);
        la   = (d == 0) || (d == 2);
        eb   = fr ? (fw ? 8'hFF : 8'h03) : b;
        if (frow) begin
            if (k == 1) return {1'b1, eb};
            if (k == 2) return ff ? 9'd0 : {1'b1, eb};
            if (k == 3) return ff ? {1'b1, eb} : 9'd0;
            return 9'd0;
        end
        if (fr) begin
            if (k == 2) return {1'b1, fw ? 8'hE0 : 8'hF6};
            if (k >= 1 && k <= 6) return {1'b1, eb};
            return 9'd0;
        end
        case (k)
            1: return {1'b1, b};
            2: return {1'b1, 8'h03};
            3: return {1'b1, la ? 8'hFF : b};
            4: return {1'b1, la ? 8'h03 : b};
            5: return {1'b1, la ? b : 8'hFF};
            6: return {1'b1, la ? b : 8'h03};
            default: return 9'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        exp_t e;
        cyc <= cyc + 1;
        #1;
        if (sb.size() != 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("valid", {31'd0, valid_out}, 32'd1);
            check("pixel", {24'd0, pixel_out}, {24'd0, e.v[7:0]});
            check("opaque", {31'd0, opaque_out}, {31'd0, e.v[8]});
        end else begin
            check("idle", {22'd0, valid_out, pixel_out, opaque_out}, 32'd0);
        end
    end

    task automatic send(input int r0, input int c0, input int k0,
                        input int d0, input logic [7:0] b0, input logic h0,
                        input int r1, input int c1, input int k1,
                        input int d1, input logic [7:0] b1, input logic h1);
        exp_t       e;
        logic [8:0] e0;
        logic [8:0] e1;
        row_in     = '0;
        col_in     = '0;
        dir_in     = '0;
        hit_in     = '0;
        body_color = '0;
        row_in[3:0]      = 4'(r0);
        col_in[3:0]      = 4'(c0);
        dir_in[1:0]      = 2'(d0);
        body_color[7:0]  = b0;
        hit_in[0]        = h0;
        row_in[7:4]      = 4'(r1);
        col_in[7:4]      = 4'(c1);
        dir_in[3:2]      = 2'(d1);
        body_color[15:8] = b1;
        hit_in[1]        = h1;
        valid_in         = 1'b1;
        e0 = h0 ? model(k0, r0, d0, b0) : 9'd0;
        e1 = h1 ? model(k1, r1, d1, b1) : 9'd0;
        e.due = cyc + 2;
        e.v   = e0[8] ? e0 : e1;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic send1(input int r, input int c, input int k,
                         input int d, input logic [7:0] b);
        send(r, c, k, d, b, 1'b1, 0, 0, 0, 0, 8'd0, 1'b0);
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        hit_in   = '0;
        repeat (n) @(negedge clk);
    endtask

    task automatic tick(input logic start);
        valid_in     = 1'b0;
        frame_tick   = 1'b1;
        fright_start = start;
        @(negedge clk);
        frame_tick   = 1'b0;
        fright_start = 1'b0;
        if (start) cnt = FT;
        else if (cnt > 0) cnt--;
        if (fdv == FRD - 1) begin
            fdv = 0;
            ff  = ~ff;
        end else begin
            fdv++;
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        frame_tick   = 1'b0;
        fright_start = 1'b0;
        valid_in     = 1'b0;
        row_in       = '0;
        col_in       = '0;
        dir_in       = '0;
        hit_in       = '0;
        body_color   = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_pixel", {24'd0, pixel_out}, 32'd0);
        check("rst_opaque", {31'd0, opaque_out}, 32'd0);
        check("rst_fright", {31'd0, frightened}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // direction-dependent eyes, ghost 0 only
        send1(5, 6, 3, 0, 8'hE0);
        idle(2);
        send1(5, 6, 3, 1, 8'hE0);
        idle(2);
        send1(5, 6, 3, 2, 8'hE0);
        send1(5, 6, 3, 3, 8'hE0);
        send1(3, 5, 4, 2, 8'hE0);
        send1(3, 5, 4, 3, 8'hE0);
        idle(3);

        // priority between ghosts 0 and 1
        send(8, 8, 1, 0, 8'hE0, 1'b1, 8, 8, 1, 0, 8'h1F, 1'b1);
        send(8, 8, 1, 0, 8'hE0, 1'b0, 8, 8, 1, 0, 8'h1F, 1'b1);
        send(0, 0, 0, 0, 8'hE0, 1'b1, 15, 5, 0, 0, 8'h1F, 1'b1);
        send(0, 0, 0, 0, 8'hE0, 1'b1, 8, 8, 1, 1, 8'h1C, 1'b1);
        idle(3);

        // frill animation
        send1(14, 1, 2, 0, 8'h1C);
        send1(14, 3, 3, 0, 8'h1C);
        idle(2);
        repeat (FRD) tick(1'b0);
        send1(14, 1, 2, 0, 8'h1C);
        send1(14, 3, 3, 0, 8'h1C);
        send1(13, 5, 2, 1, 8'h1C);
        idle(3);

        // frightened timing, restart on the final tick, then expiry
        tick(1'b1);
        check("fright_on", {31'd0, frightened}, 32'd1);
        send1(8, 8, 1, 0, 8'hE0);
        send1(5, 6, 2, 0, 8'hE0);
        idle(2);
        while (cnt > 1) begin
            tick(1'b0);
            send1(8, 8, 1, 0, 8'hE0);
            if (cnt % 16 == 3) begin
                send1(5, 6, 2, 1, 8'hE0);
                send1(14, 1, 2, 1, 8'hE0);
            end
            check("fright_lvl", {31'd0, frightened}, {31'd0, cnt != 0});
        end
        tick(1'b1);
        check("fright_restart", {31'd0, frightened}, 32'd1);
        send1(8, 8, 1, 0, 8'hE0);
        while (cnt > 0) begin
            tick(1'b0);
            send1(8, 8, 1, 0, 8'hE0);
            check("fright_lvl2", {31'd0, frightened}, {31'd0, cnt != 0});
        end
        send1(5, 6, 3, 0, 8'hE0);
        idle(3);

        // reset with pixels in flight
        tick(1'b1);
        send1(8, 8, 1, 0, 8'hE0);
        send1(8, 8, 1, 0, 8'h1F);
        rst_n    = 1'b0;
        valid_in = 1'b0;
        sb.delete();
        cnt = 0;
        fdv = 0;
        ff  = 1'b0;
        #1;
        check("rst_mid_valid", {31'd0, valid_out}, 32'd0);
        check("rst_mid_fright", {31'd0, frightened}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        send1(5, 6, 3, 0, 8'h1C);
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
